// File: rtl/npc_state_sequencer.sv
// NPC state sequencer: walks a three-level three-phase converter from its
// present state to a requested one, one level per phase per update.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_state  in   requested state, 9*la + 3*lb + lc, levels 0=N 1=O 2=P
//   req_valid  in   request strobe
//   req_ready  out  high in IDLE only; a request is taken when valid&ready
//   state      out  present converter state, same encoding as req_state
//   busy       out  high while stepping or dwelling
//   state_chg  out  one-cycle pulse when state has just taken a new value
//   err        out  one-cycle pulse when an out-of-range request is rejected
module npc_state_sequencer #(
    parameter int unsigned MIN_DWELL = 100,
    parameter int unsigned CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] req_state,
    input  logic       req_valid,
    output logic       req_ready,
    output logic [4:0] state,
    output logic       busy,
    output logic       state_chg,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        DWELL = 2'd2
    } fsm_t;

    // All phases at O.
    localparam logic [4:0] ST_RESET = 5'd13;
    localparam logic [4:0] ST_MAX   = 5'd26;

    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(MIN_DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // With a one-cycle dwell there is no room for a DWELL cycle between
    // consecutive updates, so STEP must chain straight into STEP.
    localparam bit SINGLE_CYCLE = (MIN_DWELL == 1);

    fsm_t             r_fsm;
    logic [4:0]       r_state;
    logic [4:0]       r_tgt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_chg;
    logic             r_err;

    fsm_t             w_fsm_nxt;
    logic [4:0]       w_state_nxt;
    logic [4:0]       w_tgt_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_chg_nxt;
    logic             w_err_nxt;

    logic             w_accept;
    logic             w_illegal;
    logic [4:0]       w_stepped;
    logic             w_at_tgt;

    // Move one level toward the target level, or hold.
    function automatic logic [1:0] lvl_step(
        input logic [1:0] cur,
        input logic [1:0] tgt
    );
        logic [1:0] r;
        if (cur < tgt) begin
            r = cur + 2'd1;
        end else if (cur > tgt) begin
            r = cur - 2'd1;
        end else begin
            r = cur;
        end
        return r;
    endfunction

    // Split both states into phase levels, step each phase, and rebuild.
    // Seven-bit intermediates keep 9*2 + 3*2 + 2 = 26 well clear of overflow.
    function automatic logic [4:0] state_step(
        input logic [4:0] cur,
        input logic [4:0] tgt
    );
        logic [6:0] c;
        logic [6:0] t;
        logic [1:0] ca, cb, cc;
        logic [1:0] ta, tb, tc;
        logic [1:0] na, nb, nc;
        logic [6:0] sum;
        c   = {2'b00, cur};
        t   = {2'b00, tgt};
        ca  = 2'(c / 7'd9);
        cb  = 2'((c / 7'd3) % 7'd3);
        cc  = 2'(c % 7'd3);
        ta  = 2'(t / 7'd9);
        tb  = 2'((t / 7'd3) % 7'd3);
        tc  = 2'(t % 7'd3);
        na  = lvl_step(ca, ta);
        nb  = lvl_step(cb, tb);
        nc  = lvl_step(cc, tc);
        sum = 7'd9 * {5'b0, na}
            + 7'd3 * {5'b0, nb}
            + {5'b0, nc};
        return 5'(sum);
    endfunction

    assign w_accept  = req_valid && (r_fsm == IDLE);
    assign w_illegal = (req_state > ST_MAX);
    assign w_stepped = state_step(r_state, r_tgt);
    assign w_at_tgt  = (r_state == r_tgt);

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_cnt_nxt   = r_cnt;
        w_chg_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        unique case (r_fsm)
            IDLE: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        w_err_nxt = 1'b1;
                    end else if (req_state != r_state) begin
                        w_tgt_nxt = req_state;
                        w_fsm_nxt = STEP;
                    end
                end
            end
            STEP: begin
                w_state_nxt = w_stepped;
                w_chg_nxt   = 1'b1;
                w_cnt_nxt   = DWELL_LD;
                if (SINGLE_CYCLE && (w_stepped != r_tgt)) begin
                    w_fsm_nxt = STEP;
                end else begin
                    w_fsm_nxt = DWELL;
                end
            end
            DWELL: begin
                if (r_cnt != CNT_ZERO) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
                // The STEP cycle itself is the last cycle of the dwell, so
                // leave one count early when another update is pending.
                if (!w_at_tgt && (r_cnt <= CNT_ONE)) begin
                    w_fsm_nxt = STEP;
                end else if (w_at_tgt && (r_cnt == CNT_ZERO)) begin
                    w_fsm_nxt = IDLE;
                end
            end
            default: begin
                w_fsm_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= IDLE;
            r_state <= ST_RESET;
            r_tgt   <= ST_RESET;
            r_cnt   <= '0;
            r_chg   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_chg   <= w_chg_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign req_ready = (r_fsm == IDLE);
    assign busy      = (r_fsm != IDLE);
    assign state     = r_state;
    assign state_chg = r_chg;
    assign err       = r_err;

endmodule

// File: tb/tb_npc_state_sequencer.sv
// Directed bench for npc_state_sequencer at MIN_DWELL=4.
// Expected state updates and error pulses are queued when a request is sent.
module tb_npc_state_sequencer;

    localparam int MD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req_state = 5'd0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [4:0] state;
    logic       busy;
    logic       state_chg;
    logic       err;

    npc_state_sequencer #(
        .MIN_DWELL(MD),
        .CNT_W    (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_state(req_state),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .state    (state),
        .busy     (busy),
        .state_chg(state_chg),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [4:0] st;
    } ev_t;

    ev_t        sb_q[$];
    int         upd_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [4:0] prev_st = 5'd13;

    function automatic int max_phase_delta(input int a, input int b);
        int d;
        int x;
        d = 0;
        for (int i = 0; i < 3; i++) begin
            x = (a % 3) - (b % 3);
            if (x < 0) x = -x;
            if (x > d) d = x;
            a = a / 3;
            b = b / 3;
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge and score any event.
    task automatic tick();
        ev_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (state_chg === 1'b1) upd_q.push_back(cyc);
        if (state_chg === 1'b1 || err === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", {30'd0, state_chg, err}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_kind", {31'd0, err}, {31'd0, e.is_err});
                chk("sb_state", {27'd0, state}, {27'd0, e.st});
            end
        end
        if (rst_n === 1'b1 && state !== prev_st) begin
            chk("phase_jump_le1",
                (max_phase_delta(int'(prev_st), int'(state)) <= 1), 1);
        end
        prev_st = state;
    endtask

    task automatic send(input logic [4:0] s);
        req_state = s;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic run_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", state, 13);
        chk("rst_busy", busy, 0);
        chk("rst_chg", state_chg, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", req_ready, 1);
        chk("rel_state", state, 13);
        prev_st = state;

        // Single step 13 -> 26
        upd_q.delete();
        sb_q.push_back(ev_t'{1'b0, 5'd26});
        send(5'd26);
        acc = cyc;
        chk("acc_state_hold", state, 13);
        chk("acc_busy", busy, 1);
        chk("acc_ready", req_ready, 0);
        run_idle(n);
        chk("single_busy_cycles", n, 5);
        chk("single_ready", req_ready, 1);
        chk("single_final", state, 26);
        chk("single_upd_count", upd_q.size(), 1);
        if (upd_q.size() >= 1) chk("single_latency", upd_q[0] - acc, 1);

        // Two steps 26 -> 13 -> 0
        upd_q.delete();
        sb_q.push_back(ev_t'{1'b0, 5'd13});
        sb_q.push_back(ev_t'{1'b0, 5'd0});
        send(5'd0);
        acc = cyc;
        run_idle(n);
        chk("two_busy_cycles", n, 9);
        chk("two_final", state, 0);
        chk("two_upd_count", upd_q.size(), 2);
        if (upd_q.size() >= 2) begin
            chk("two_first_latency", upd_q[0] - acc, 1);
            chk("two_spacing", upd_q[1] - upd_q[0], MD);
        end

        // Illegal requests 27 and 31
        sb_q.push_back(ev_t'{1'b1, 5'd0});
        send(5'd27);
        chk("ill27_err", err, 1);
        chk("ill27_busy", busy, 0);
        chk("ill27_ready", req_ready, 1);
        chk("ill27_state", state, 0);
        tick();
        chk("ill27_err_clr", err, 0);
        sb_q.push_back(ev_t'{1'b1, 5'd0});
        send(5'd31);
        chk("ill31_err", err, 1);
        chk("ill31_ready", req_ready, 1);
        tick();
        chk("ill31_err_clr", err, 0);
        chk("ill31_state", state, 0);

        // Same-state request is a no-op
        send(5'd0);
        chk("noop_busy", busy, 0);
        chk("noop_err", err, 0);
        tick();
        chk("noop_chg", state_chg, 0);
        chk("noop_state", state, 0);

        // Back to 13
        sb_q.push_back(ev_t'{1'b0, 5'd13});
        send(5'd13);
        run_idle(n);
        chk("back13_state", state, 13);

        // Request 2 while dwelling after 13 -> 26
        sb_q.push_back(ev_t'{1'b0, 5'd26});
        send(5'd26);
        tick();
        chk("busyreq_upd", state, 26);
        req_state = 5'd2;
        req_valid = 1'b1;
        tick();
        chk("busyreq_ready", req_ready, 0);
        tick();
        req_valid = 1'b0;
        run_idle(n);
        chk("busyreq_idle_cycles", n, 2);
        chk("busyreq_state", state, 26);
        repeat (10) tick();
        chk("busyreq_later_state", state, 26);
        chk("busyreq_later_busy", busy, 0);

        // Reset between the 26 -> 13 and 13 -> 0 updates
        upd_q.delete();
        sb_q.push_back(ev_t'{1'b0, 5'd13});
        send(5'd0);
        tick();
        tick();
        chk("mid_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", state, 13);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_chg", state_chg, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) tick();
        chk("mid_after_state", state, 13);
        chk("mid_after_busy", busy, 0);
        chk("mid_upd_count", upd_q.size(), 1);

        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
